// File: rtl/reg_bank_en.sv
// Bank of NUM_REGS x WIDTH registers with one LOAD/INC/DEC/CLR write port, two combinational
// read ports and a sticky overflow flag. Define REG_BANK_SAT_EN for saturating INC/DEC.
module reg_bank_en #(
    parameter int WIDTH    = 20,
    parameter int NUM_REGS = 8,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_op,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_sel_a,
    output logic [WIDTH-1:0] rd_a,
    input  logic [SEL_W-1:0] rd_sel_b,
    output logic [WIDTH-1:0] rd_b,
    output logic             zero_a,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0]    regs_reg  [NUM_REGS];
    logic [WIDTH-1:0]    reg_next  [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_hit;
    logic                ovf_reg;
    logic                ovf_next;

    // Each register decodes its own write; an out-of-range wr_sel matches no slot and is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic             hit;
            logic             wrap_evt;
            logic [WIDTH-1:0] cur;
            logic [WIDTH-1:0] nxt;

            assign cur = regs_reg[gi];
            assign hit = wr_en && (wr_sel == SEL_W'(gi));

            always_comb begin
                nxt      = cur;
                wrap_evt = 1'b0;
                if (hit) begin
                    case (wr_op)
                        OP_LOAD: nxt = wr_data;
                        OP_INC: begin
                            if (cur == ONES) begin
                                wrap_evt = 1'b1;
`ifdef REG_BANK_SAT_EN
                                nxt = ONES;
`else
                                nxt = '0;
`endif
                            end else begin
                                nxt = cur + WIDTH'(1);
                            end
                        end
                        OP_DEC: begin
                            if (cur == '0) begin
                                wrap_evt = 1'b1;
`ifdef REG_BANK_SAT_EN
                                nxt = '0;
`else
                                nxt = ONES;
`endif
                            end else begin
                                nxt = cur - WIDTH'(1);
                            end
                        end
                        OP_CLR:  nxt = '0;
                        default: nxt = cur;
                    endcase
                end
            end

            assign reg_next[gi] = nxt;
            assign ovf_hit[gi]  = wrap_evt;
        end
    endgenerate

    // A new overflow event beats a simultaneous clear request.
    always_comb begin
        ovf_next = ovf_reg;
        if (|ovf_hit) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            ovf_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= reg_next[i];
            end
            ovf_reg <= ovf_next;
        end
    end

    // Read ports default to 0 so unmapped indices of a non-power-of-2 bank read as empty.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel_a == SEL_W'(i)) rd_a = regs_reg[i];
            if (rd_sel_b == SEL_W'(i)) rd_b = regs_reg[i];
        end
    end

    assign zero_a = (rd_a == '0);
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_reg_bank_en.sv
// Directed bench for reg_bank_en: a vector table for single-edge operations, hand sequences
// for reset, pre-edge visibility, mid-run reset and a 6-entry bank's out-of-range indices.
module tb_reg_bank_en;

`ifdef REG_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [19:0] ALL1 = 20'hFFFFF;
    localparam logic [19:0] WRAP_INC = SAT ? 20'hFFFFF : 20'h00000;
    localparam logic [19:0] WRAP_DEC = SAT ? 20'h00000 : 20'hFFFFF;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        wr_en, ovf_clr;
    logic [1:0]  wr_op;
    logic [2:0]  wr_sel, rd_sel_a, rd_sel_b;
    logic [19:0] wr_data, rd_a, rd_b;
    logic        zero_a, ovf;

    logic        s_wr_en, s_ovf_clr;
    logic [1:0]  s_wr_op;
    logic [2:0]  s_wr_sel, s_rd_sel_a, s_rd_sel_b;
    logic [19:0] s_wr_data, s_rd_a, s_rd_b;
    logic        s_zero_a, s_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_bank_en #(.WIDTH(20), .NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_sel(wr_sel),
        .wr_data(wr_data), .rd_sel_a(rd_sel_a), .rd_a(rd_a), .rd_sel_b(rd_sel_b),
        .rd_b(rd_b), .zero_a(zero_a), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    reg_bank_en #(.WIDTH(20), .NUM_REGS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_op(s_wr_op), .wr_sel(s_wr_sel),
        .wr_data(s_wr_data), .rd_sel_a(s_rd_sel_a), .rd_a(s_rd_a), .rd_sel_b(s_rd_sel_b),
        .rd_b(s_rd_b), .zero_a(s_zero_a), .ovf(s_ovf), .ovf_clr(s_ovf_clr)
    );

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [19:0] data;
        logic        clr;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [19:0] exp_a;
        logic [19:0] exp_b;
        logic        exp_z;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] op, input logic [2:0] sel,
                         input logic [19:0] data, input logic clr,
                         input logic [2:0] ra, input logic [2:0] rb);
        wr_en = en; wr_op = op; wr_sel = sel; wr_data = data; ovf_clr = clr;
        rd_sel_a = ra; rd_sel_b = rb;
    endtask

    initial begin
        drive(1'b0, 2'b00, 3'd0, 20'h0, 1'b0, 3'd0, 3'd0);
        s_wr_en = 1'b0; s_wr_op = 2'b00; s_wr_sel = 3'd0; s_wr_data = 20'h0;
        s_ovf_clr = 1'b0; s_rd_sel_a = 3'd0; s_rd_sel_b = 3'd0;
        rst_n = 1'b0;

        //            en  op     sel   data      clr   ra    rb    exp_a      exp_b     z     ovf
        vecs[0]  = '{1'b1, 2'b00, 3'd3, 20'h12345, 1'b0, 3'd3, 3'd3, 20'h12345, 20'h12345, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 3'd1, ALL1,      1'b0, 3'd1, 3'd3, ALL1,      20'h12345, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 3'd1, 20'h0,     1'b0, 3'd1, 3'd1, WRAP_INC,  WRAP_INC,  !SAT, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 3'd1, 20'h0,     1'b1, 3'd1, 3'd3, WRAP_INC,  20'h12345, !SAT, 1'b0};
        vecs[4]  = '{1'b1, 2'b11, 3'd2, 20'h777,   1'b0, 3'd2, 3'd3, 20'h0,     20'h12345, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 3'd2, 20'h0,     1'b1, 3'd2, 3'd2, WRAP_DEC,  WRAP_DEC,  SAT,  1'b1};
        vecs[6]  = '{1'b0, 2'b11, 3'd3, 20'h0,     1'b0, 3'd3, 3'd2, 20'h12345, WRAP_DEC,  1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 3'd0, 20'h0,     1'b1, 3'd3, 3'd3, 20'h12345, 20'h12345, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 3'd3, 20'h0,     1'b0, 3'd3, 3'd0, 20'h12346, 20'h0,     1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 3'd3, 20'h0,     1'b0, 3'd3, 3'd3, 20'h12345, 20'h12345, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 3'd7, 20'h00001, 1'b0, 3'd7, 3'd0, 20'h00001, 20'h0,     1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 3'd7, 20'h0,     1'b0, 3'd7, 3'd3, 20'h0,     20'h12345, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 3'd7, 20'h0,     1'b0, 3'd7, 3'd7, WRAP_DEC,  WRAP_DEC,  SAT,  1'b1};
        vecs[13] = '{1'b0, 2'b00, 3'd0, 20'h5,     1'b1, 3'd0, 3'd7, 20'h0,     WRAP_DEC,  1'b1, 1'b0};

        // Reset state across all indices
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rd_sel_a = 3'(i); rd_sel_b = 3'(i);
            #1;
            chk($sformatf("reset_rd_a[%0d]", i), 32'(rd_a), 32'h0);
            chk($sformatf("reset_rd_b[%0d]", i), 32'(rd_b), 32'h0);
            chk($sformatf("reset_zero_a[%0d]", i), 32'(zero_a), 32'h1);
        end
        chk("reset_ovf", 32'(ovf), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rd_sel_a = 3'd5; rd_sel_b = 3'd6; #1;
        chk("post_reset_rd_a", 32'(rd_a), 32'h0);
        chk("post_reset_rd_b", 32'(rd_b), 32'h0);
        chk("post_reset_ovf", 32'(ovf), 32'h0);

        // Table-driven single-edge operations
        for (int v = 0; v < 14; v++) begin
            @(posedge clk); #1;
            drive(vecs[v].en, vecs[v].op, vecs[v].sel, vecs[v].data, vecs[v].clr,
                  vecs[v].ra, vecs[v].rb);
            @(negedge clk); #2;
            $display("vec %0d: en=%0b op=%0d sel=%0d data=0x%0h clr=%0b -> a=0x%0h b=0x%0h z=%0b ovf=%0b",
                     v, vecs[v].en, vecs[v].op, vecs[v].sel, vecs[v].data, vecs[v].clr,
                     rd_a, rd_b, zero_a, ovf);
            chk($sformatf("vec%0d_rd_a", v), 32'(rd_a), 32'(vecs[v].exp_a));
            chk($sformatf("vec%0d_rd_b", v), 32'(rd_b), 32'(vecs[v].exp_b));
            chk($sformatf("vec%0d_zero_a", v), 32'(zero_a), 32'(vecs[v].exp_z));
            chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
        end

        // No write-through before the falling edge
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 3'd4, 20'hABCDE, 1'b0, 3'd4, 3'd4);
        #1;
        chk("pre_edge_rd_a", 32'(rd_a), 32'h0);
        chk("pre_edge_zero_a", 32'(zero_a), 32'h1);
        @(negedge clk); #2;
        chk("post_edge_rd_a", 32'(rd_a), 32'hABCDE);
        chk("post_edge_rd_b", 32'(rd_b), 32'hABCDE);
        $display("seq pre/post edge load r4: a=0x%0h", rd_a);

        // Set ovf, then count r0 up and reset asynchronously between edges
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 3'd5, 20'h0, 1'b0, 3'd0, 3'd5);
        @(negedge clk); #2;
        chk("dec_r5_ovf", 32'(ovf), 32'h1);
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 3'd0, 20'h0, 1'b0, 3'd0, 3'd5);
        repeat (3) @(negedge clk);
        #2;
        chk("inc_r0_x3", 32'(rd_a), 32'h3);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_r0", 32'(rd_a), 32'h0);
        chk("midrst_r5", 32'(rd_b), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        @(negedge clk); #2;
        chk("resume_r0_1", 32'(rd_a), 32'h1);
        @(negedge clk); #2;
        chk("resume_r0_2", 32'(rd_a), 32'h2);
        $display("seq mid-run reset: r0=0x%0h ovf=%0b", rd_a, ovf);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 3'd0, 20'h0, 1'b0, 3'd0, 3'd0);

        // Six-entry bank: indices 6 and 7 are unmapped
        @(posedge clk); #1;
        s_wr_en = 1'b1; s_wr_op = 2'b00; s_wr_sel = 3'd5; s_wr_data = 20'h00ABC;
        s_rd_sel_a = 3'd5; s_rd_sel_b = 3'd6;
        @(negedge clk); #2;
        chk("nr6_load_r5", 32'(s_rd_a), 32'h00ABC);
        chk("nr6_rd_b_sel6", 32'(s_rd_b), 32'h0);
        @(posedge clk); #1;
        s_wr_op = 2'b00; s_wr_sel = 3'd6; s_wr_data = 20'h11111;
        s_rd_sel_a = 3'd6; s_rd_sel_b = 3'd5;
        @(negedge clk); #2;
        chk("nr6_oor_load_rd_a", 32'(s_rd_a), 32'h0);
        chk("nr6_oor_zero_a", 32'(s_zero_a), 32'h1);
        chk("nr6_oor_r5_kept", 32'(s_rd_b), 32'h00ABC);
        @(posedge clk); #1;
        s_wr_op = 2'b10; s_wr_sel = 3'd7; s_rd_sel_a = 3'd7;
        @(negedge clk); #2;
        chk("nr6_oor_dec_ovf", 32'(s_ovf), 32'h0);
        chk("nr6_oor_dec_rd_a", 32'(s_rd_a), 32'h0);
        $display("seq six-entry bank: r5=0x%0h ovf=%0b", s_rd_b, s_ovf);
        @(posedge clk); #1;
        s_wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
